hyperram_responder: RTL and testbench
=====================================

HYPERRAM_RESPONDER -- requirements
Module: hyperram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, word-address width of internal memory (2^MEM_AW 16-bit words).
REQ-002 SHALL have parameter LATENCY, default 6, initial-access latency in CK cycles, always applied doubled (2*LATENCY).
REQ-003 SHALL have parameter ID0, default 16'h0C81, value returned on register-space read at address 0.
REQ-004 SHALL have ports, with reset rst_ni asynchronous, active-low, and clock clk_i:
 - clk_i  in  1  system clock, at least 4x CK frequency
 - rst_ni  in  1  async active-low reset
 - cs_ni  in  1  chip select, active-low
 - ck_i  in  1  HyperBus CK, sampled on clk_i
 - dq_i  in  8  DQ input
 - dq_o  out  8  DQ output
 - dq_oe_o  out  1  DQ output enable
 - rwds_i  in  1  write byte mask (1 = masked)
 - rwds_o  out  1  read strobe / latency indicator
 - rwds_oe_o  out  1  RWDS output enable

Function
REQ-005 SHALL register ck_i once and define a beat as any cycle where ck_i differs from its registered copy; a rise-beat has ck_i=1, a fall-beat has ck_i=0.
REQ-006 SHALL implement states IDLE, CA, LAT, WRITE, READ.
REQ-007 IDLE->CA when cs_ni=0; any state->IDLE in the cycle after cs_ni=1 is sampled; dq_oe_o and rwds_oe_o drop in that same transition cycle.
REQ-008 In CA, SHALL shift in dq_i on 6 consecutive beats (first beat = CA[47:40]), driving rwds_oe_o=1, rwds_o=1 throughout CA.
REQ-009 CA decode: CA[47]=1 read, 0 write; CA[46]=1 register space; CA[45]=1 linear burst, 0 wrapped; word address = {CA[44:16],CA[2:0]} truncated to MEM_AW bits.
REQ-010 Register-space write SHALL take zero latency: CA->WRITE directly, first two data beats stored into CR0 (reset 16'h8F1F), further beats ignored.
REQ-011 Otherwise after CA, SHALL load latency counter with 2*LATENCY, enter LAT, decrement on each rise-beat; the rise-beat on which the counter reaches 0 is the first data beat.
REQ-012 rwds_oe_o SHALL be 0 in LAT and WRITE.
REQ-013 WRITE: rise-beat byte -> data[15:8], fall-beat byte -> data[7:0]; each byte written only if rwds_i=0 on its beat; word committed after the fall-beat, then address advances.
REQ-014 READ: within 1 clk_i of each rise-beat drive dq_o=mem[addr][15:8], rwds_o=1; of each fall-beat dq_o=mem[addr][7:0], rwds_o=0; dq_oe_o=rwds_oe_o=1; address advances after fall-beat.
REQ-015 Register-space read SHALL return ID0 when word address bit0=0, else CR0, with latency as REQ-011.
REQ-016 Linear burst SHALL wrap modulo 2^MEM_AW; wrapped burst SHALL wrap within the aligned 16-word group (addr[3:0] increments, upper bits held).
REQ-017 cs_ni deasserted mid-word during WRITE SHALL discard the incomplete word; completed words remain written.
REQ-018 cs_ni deasserted during CA or LAT SHALL abort with no memory side effect.
REQ-019 Memory contents SHALL NOT be cleared by reset; CR0 SHALL be.

Reset
REQ-020 While rst_ni=0: state IDLE, dq_o=0, dq_oe_o=0, rwds_o=0, rwds_oe_o=0, latency counter 0, CR0=16'h8F1F, registered ck=0.
REQ-021 Reset asserted mid-transaction SHALL release bus (all OE=0) immediately, asynchronously.

Verification
REQ-022 Write CA 0x20_0000_0000_03 (mem, linear, addr 3), after 12 rise-beats write 4 words 0x0F03..0x0F06 -> read back addr 3..6 returns 0x0F03..0x0F06, first byte driven 12 rise-beats after CA.
REQ-023 Write word 0xABCD at addr 5 with rwds_i=1 on fall-beat -> read addr 5 returns 0xAB followed by previous low byte.
REQ-024 Wrapped read of 4 words from addr 14 (mem 14,15 = 0x1111,0x2222; 0,1 = 0x3333,0x4444) -> 0x1111,0x2222,0x3333,0x4444.
REQ-025 Register write 0x8F17 to CR0 (zero latency), register read addr 1 -> 0x8F17; addr 0 -> 0x0C81.
REQ-026 Linear read at addr 1023, length 2 -> words from 1023 then 0.
REQ-027 cs_ni high after 3 CA beats, then new transaction -> no memory change, second transaction completes correctly; cs_ni high mid-READ -> dq_oe_o=0 within 1 cycle.

Source files
------------

// File: rtl/hyperram_responder.sv
// HyperRAM device-side responder: CA capture, latency, burst read/write.
// Internal 16-bit word memory plus ID0/CR0 register space.
module hyperram_responder #(
  parameter int          MEM_AW  = 10,
  parameter int          LATENCY = 6,
  parameter logic [15:0] ID0     = 16'h0C81
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cs_ni,
  input  logic       ck_i,
  input  logic [7:0] dq_i,
  output logic [7:0] dq_o,
  output logic       dq_oe_o,
  input  logic       rwds_i,
  output logic       rwds_o,
  output logic       rwds_oe_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CA,
    S_LAT,
    S_WRITE,
    S_READ
  } state_t;

  localparam logic [7:0] LAT2 = 8'(2 * LATENCY);
  localparam logic [15:0] CR0_RST = 16'h8F1F;

  state_t              r_state;
  logic                r_ck;
  logic [2:0]          r_bcnt;
  logic [39:0]         r_ca;
  logic [7:0]          r_lat;
  logic                r_rd;
  logic                r_rs;
  logic                r_lin;
  logic                r_first;
  logic [MEM_AW-1:0]   r_addr;
  logic [7:0]          r_whi;
  logic                r_mhi;
  logic [15:0]         r_cr0;
  logic [15:0]         r_mem [0:(1<<MEM_AW)-1];

  logic                w_beat;
  logic                w_rise;
  logic                w_fall;
  logic [47:0]         w_ca;
  logic [31:0]         w_ca_addr;
  logic                w_last_lat;
  logic                w_data_beat;
  logic                w_commit;
  logic [15:0]         w_rdata;
  logic [MEM_AW-1:0]   w_addr_nx;
  logic                w_unused;

  assign w_beat = ck_i ^ r_ck;
  assign w_rise = w_beat & ck_i;
  assign w_fall = w_beat & ~ck_i;

  assign w_ca      = {r_ca, dq_i};
  assign w_ca_addr = {w_ca[44:16], w_ca[2:0]};

  assign w_last_lat = (r_state == S_LAT) && w_rise
                      && (r_lat == 8'd1);
  assign w_data_beat = w_last_lat
                       || (((r_state == S_WRITE)
                            || (r_state == S_READ)) && w_beat);
  assign w_commit = !cs_ni && w_data_beat && w_fall
                    && !r_rd && !r_rs;

  assign w_rdata = r_rs ? (r_addr[0] ? r_cr0 : ID0)
                        : r_mem[r_addr];

  // Wrapped bursts stay inside the aligned 16-word group.
  assign w_addr_nx = r_lin
    ? r_addr + MEM_AW'(1)
    : {r_addr[MEM_AW-1:4], r_addr[3:0] + 4'd1};

  assign w_unused = ^{w_ca[15:3], w_ca_addr[31:MEM_AW]};

  // Transaction FSM with registered bus outputs and CR0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_ck      <= 1'b0;
      r_bcnt    <= '0;
      r_ca      <= '0;
      r_lat     <= '0;
      r_rd      <= 1'b0;
      r_rs      <= 1'b0;
      r_lin     <= 1'b0;
      r_first   <= 1'b0;
      r_addr    <= '0;
      r_whi     <= '0;
      r_mhi     <= 1'b0;
      r_cr0     <= CR0_RST;
      dq_o      <= '0;
      dq_oe_o   <= 1'b0;
      rwds_o    <= 1'b0;
      rwds_oe_o <= 1'b0;
    end else begin
      r_ck <= ck_i;
      if (cs_ni) begin
        r_state   <= S_IDLE;
        dq_oe_o   <= 1'b0;
        rwds_oe_o <= 1'b0;
        rwds_o    <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state   <= S_CA;
            r_bcnt    <= '0;
            dq_oe_o   <= 1'b0;
            rwds_oe_o <= 1'b1;
            rwds_o    <= 1'b1;
          end
          S_CA: begin
            if (w_beat) begin
              r_ca   <= w_ca[39:0];
              r_bcnt <= r_bcnt + 3'd1;
              if (r_bcnt == 3'd5) begin
                r_rd      <= w_ca[47];
                r_rs      <= w_ca[46];
                r_lin     <= w_ca[45];
                r_addr    <= w_ca_addr[MEM_AW-1:0];
                r_first   <= 1'b1;
                rwds_oe_o <= 1'b0;
                rwds_o    <= 1'b0;
                if (!w_ca[47] && w_ca[46]) begin
                  r_state <= S_WRITE;
                end else begin
                  r_lat   <= LAT2;
                  r_state <= S_LAT;
                end
              end
            end
          end
          S_LAT: begin
            if (w_rise) begin
              r_lat <= r_lat - 8'd1;
              if (r_lat == 8'd1) begin
                r_state <= r_rd ? S_READ : S_WRITE;
              end
            end
          end
          S_WRITE, S_READ: begin
          end
          default: r_state <= S_IDLE;
        endcase

        if (w_data_beat) begin
          if (r_rd) begin
            dq_oe_o   <= 1'b1;
            rwds_oe_o <= 1'b1;
            if (w_rise) begin
              dq_o   <= w_rdata[15:8];
              rwds_o <= 1'b1;
            end else begin
              dq_o   <= w_rdata[7:0];
              rwds_o <= 1'b0;
              r_addr <= w_addr_nx;
            end
          end else if (w_rise) begin
            r_whi <= dq_i;
            r_mhi <= rwds_i;
            if (r_rs && r_first) begin
              r_cr0[15:8] <= dq_i;
            end
          end else begin
            if (r_rs && r_first) begin
              r_cr0[7:0] <= dq_i;
            end
            r_first <= 1'b0;
            r_addr  <= w_addr_nx;
          end
        end
      end
    end
  end

  // Commit a completed word with per-byte masking; never reset.
  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      if (!r_mhi) begin
        r_mem[r_addr][15:8] <= r_whi;
      end
      if (!rwds_i) begin
        r_mem[r_addr][7:0] <= dq_i;
      end
    end
  end

endmodule

// File: tb/tb_hyperram_responder.sv
// Directed bench for hyperram_responder: vector table
// plus hand sequences for aborts and reset.
module tb_hyperram_responder;

  logic       clk;
  logic       rst_n;
  logic       cs_n;
  logic       ck;
  logic [7:0] dqi;
  logic [7:0] dqo;
  logic       dq_oe;
  logic       rwdsi;
  logic       rwdso;
  logic       rwds_oe;

  int total = 0;
  int bad = 0;

  hyperram_responder dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .cs_ni    (cs_n),
    .ck_i     (ck),
    .dq_i     (dqi),
    .dq_o     (dqo),
    .dq_oe_o  (dq_oe),
    .rwds_i   (rwdsi),
    .rwds_o   (rwdso),
    .rwds_oe_o(rwds_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             rd;
    logic             rs;
    logic             lin;
    logic [31:0]      addr;
    int               n;
    logic [3:0][15:0] wd;
    logic [3:0][1:0]  mk;
    logic [3:0][15:0] ex;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mkv(
    input logic rd, input logic rs, input logic lin,
    input logic [31:0] addr, input int n,
    input logic [63:0] wd, input logic [7:0] mk,
    input logic [63:0] ex);
    vec_t v;
    v.rd = rd; v.rs = rs; v.lin = lin;
    v.addr = addr; v.n = n;
    v.wd = wd; v.mk = mk; v.ex = ex;
    return v;
  endfunction

  task automatic chk(input string nm, input int id,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, id, act, exp);
    end
  endtask

  task automatic beat(input logic c, input logic [7:0] d,
                      input logic m);
    @(negedge clk);
    ck = c; dqi = d; rwdsi = m;
    @(negedge clk);
  endtask

  task automatic start_ca(input logic [47:0] ca, input int nb,
                          input int id);
    @(negedge clk);
    cs_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      beat((i % 2) == 0, ca[47-8*i -: 8], 1'b0);
      if (i == 0)
        chk("ca_rwds", id, {14'd0, rwds_oe, rwdso}, 16'h0003);
    end
  endtask

  task automatic lat_wait(input int rises, input int id);
    for (int i = 0; i < rises; i++) begin
      beat(1'b1, 8'h00, 1'b0);
      beat(1'b0, 8'h00, 1'b0);
    end
    chk("lat_oe", id, {14'd0, dq_oe, rwds_oe}, 16'h0000);
  endtask

  task automatic end_txn(input int id);
    @(negedge clk);
    cs_n = 1'b1; ck = 1'b0; dqi = 8'h00; rwdsi = 1'b0;
    @(negedge clk);
    chk("end_oe", id, {14'd0, dq_oe, rwds_oe}, 16'h0000);
    @(negedge clk);
  endtask

  function automatic logic [47:0] mkca(input logic rd,
    input logic rs, input logic lin, input logic [31:0] a);
    return {rd, rs, lin, a[31:3], 13'd0, a[2:0]};
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    start_ca(mkca(v.rd, v.rs, v.lin, v.addr), 6, id);
    if (v.rd || !v.rs) lat_wait(11, id);
    for (int w = 0; w < v.n; w++) begin
      if (v.rd) begin
        beat(1'b1, 8'h00, 1'b0);
        chk("rd_hi", id, {5'd0, dq_oe, rwds_oe, rwdso, dqo},
            {8'h07, v.ex[w][15:8]});
        beat(1'b0, 8'h00, 1'b0);
        chk("rd_lo", id, {5'd0, dq_oe, rwds_oe, rwdso, dqo},
            {8'h06, v.ex[w][7:0]});
      end else begin
        beat(1'b1, v.wd[w][15:8], v.mk[w][1]);
        beat(1'b0, v.wd[w][7:0], v.mk[w][0]);
      end
    end
    end_txn(id);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; cs_n = 1'b1; ck = 1'b0;
    dqi = 8'h00; rwdsi = 1'b0;

    tbl[0]  = mkv(0, 0, 1, 3, 4,
      64'h0F06_0F05_0F04_0F03, 8'h00, 64'h0);
    tbl[1]  = mkv(1, 0, 1, 3, 4,
      64'h0, 8'h00, 64'h0F06_0F05_0F04_0F03);
    tbl[2]  = mkv(0, 0, 1, 5, 1, 64'hABCD, 8'h01, 64'h0);
    tbl[3]  = mkv(1, 0, 1, 5, 1, 64'h0, 8'h00, 64'hAB05);
    tbl[4]  = mkv(0, 0, 1, 14, 2, 64'h2222_1111, 8'h00, 64'h0);
    tbl[5]  = mkv(0, 0, 1, 0, 2, 64'h4444_3333, 8'h00, 64'h0);
    tbl[6]  = mkv(1, 0, 0, 14, 4,
      64'h0, 8'h00, 64'h4444_3333_2222_1111);
    tbl[7]  = mkv(0, 0, 1, 30, 2, 64'h6666_5555, 8'h00, 64'h0);
    tbl[8]  = mkv(0, 0, 1, 16, 1, 64'h7777, 8'h00, 64'h0);
    tbl[9]  = mkv(0, 0, 1, 32, 1, 64'h8888, 8'h00, 64'h0);
    tbl[10] = mkv(1, 0, 0, 30, 3,
      64'h0, 8'h00, 64'h7777_6666_5555);
    tbl[11] = mkv(1, 1, 1, 1, 1, 64'h0, 8'h00, 64'h8F1F);
    tbl[12] = mkv(0, 1, 1, 0, 2, 64'h1234_8F17, 8'h00, 64'h0);
    tbl[13] = mkv(1, 1, 1, 1, 1, 64'h0, 8'h00, 64'h8F17);
    tbl[14] = mkv(1, 1, 1, 0, 1, 64'h0, 8'h00, 64'h0C81);
    tbl[15] = mkv(0, 0, 1, 1023, 1, 64'hBEEF, 8'h00, 64'h0);
    tbl[16] = mkv(1, 0, 1, 1023, 2,
      64'h0, 8'h00, 64'h3333_BEEF);

    repeat (3) @(negedge clk);
    chk("rst_out", 0, {5'd0, dq_oe, rwds_oe, rwdso, dqo}, 16'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 17; i++) run_vec(tbl[i], i);

    // abort after three CA beats
    start_ca(mkca(0, 0, 1, 5), 3, 100);
    end_txn(100);
    // abort during latency of a write
    start_ca(mkca(0, 0, 1, 5), 6, 101);
    lat_wait(5, 101);
    beat(1'b1, 8'h99, 1'b0);
    end_txn(101);
    run_vec(mkv(1, 0, 1, 5, 1, 64'h0, 8'h00, 64'hAB05), 102);

    // cs high between rise and fall of second word
    start_ca(mkca(0, 0, 1, 4), 6, 103);
    lat_wait(11, 103);
    beat(1'b1, 8'h5A, 1'b0);
    beat(1'b0, 8'h5A, 1'b0);
    beat(1'b1, 8'h77, 1'b0);
    end_txn(103);
    run_vec(mkv(1, 0, 1, 4, 2, 64'h0, 8'h00, 64'hAB05_5A5A), 104);

    // cs high in mid-read drops OE within one clock
    start_ca(mkca(1, 0, 1, 3), 6, 105);
    lat_wait(11, 105);
    beat(1'b1, 8'h00, 1'b0);
    chk("mid_hi", 105, {7'd0, dq_oe, dqo}, 16'h010F);
    @(negedge clk);
    cs_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_oe", 105, {14'd0, dq_oe, rwds_oe}, 16'h0000);
    end_txn(105);

    // async reset mid-read
    start_ca(mkca(1, 0, 1, 3), 6, 106);
    lat_wait(11, 106);
    beat(1'b1, 8'h00, 1'b0);
    chk("pre_rst", 106, {14'd0, dq_oe, rwds_oe}, 16'h0003);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 106, {5'd0, dq_oe, rwds_oe, rwdso, dqo},
        16'h0000);
    @(negedge clk);
    cs_n = 1'b1; ck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(mkv(1, 1, 1, 1, 1, 64'h0, 8'h00, 64'h8F1F), 107);
    run_vec(mkv(1, 0, 1, 3, 1, 64'h0, 8'h00, 64'h0F03), 108);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
